// File: rtl/dff_pkg.sv
// Shared constants for control-pin tie-offs used across the codebase.
// Instantiators tie clr/stall to DISABLE to get a plain resettable register.
package dff_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

endpackage : dff_pkg

// File: rtl/dff.sv
// Parameterised storage register with async active-low reset, synchronous clear to INIT
// and stall-hold; q comes straight from the flop.
module dff
   import dff_pkg::*;
#(
   parameter int unsigned      WIDTH = 1,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             stall,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Priority: reset (async) > clear > stall > load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= INIT;
      end else if (clr == ENABLE) begin
         q <= INIT;
      end else if (stall == DISABLE) begin
         q <= d;
      end
   end

endmodule : dff

// File: tb/tb_dff.sv
// Bench for dff at WIDTH=1, 2 and 64: directed scenarios followed by randomized traffic
// with occasional asynchronous reset pulses, all checked against a rule-level model.
module tb_dff;
   import dff_pkg::*;

   localparam logic        I1  = 1'b1;
   localparam logic [1:0]  I2A = 2'b00;
   localparam logic [1:0]  I2B = 2'b01;
   localparam logic [63:0] I64 = 64'hDEAD_BEEF_0000_0001;
   localparam logic [1:0]  IFS = 2'b00;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        stall;
   logic        d1;
   logic [1:0]  d2;
   logic [63:0] d64;
   logic [1:0]  dfs;
   logic        q1;
   logic [1:0]  q2a;
   logic [1:0]  q2b;
   logic [63:0] q64;
   logic [1:0]  qfs;

   logic [63:0] e1, e2a, e2b, e64, efs;

   int checks = 0;
   int errors = 0;

   dff #(.WIDTH(1), .INIT(I1)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .stall(stall), .d(d1), .q(q1)
   );
   dff #(.WIDTH(2), .INIT(I2A)) u2a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .stall(stall), .d(d2), .q(q2a)
   );
   dff #(.WIDTH(2), .INIT(I2B)) u2b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .stall(stall), .d(d2), .q(q2b)
   );
   dff #(.WIDTH(64), .INIT(I64)) u64 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .stall(stall), .d(d64), .q(q64)
   );
   dff #(.WIDTH(2), .INIT(IFS)) ufs (
      .clk(clk), .rst_n(rst_n), .clr(DISABLE), .stall(DISABLE), .d(dfs), .q(qfs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // What a register holding 'cur' should contain after one rising edge.
   function automatic logic [63:0] ref_next(input logic rst, input logic c, input logic s,
                                            input logic [63:0] dv, input logic [63:0] cur,
                                            input logic [63:0] init);
      if (!rst)   return init;
      if (c)      return init;
      if (s)      return cur;
      return dv;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".w1"},  {63'b0, q1},  e1);
      check({tag, ".w2a"}, {62'b0, q2a}, e2a);
      check({tag, ".w2b"}, {62'b0, q2b}, e2b);
      check({tag, ".w64"}, q64,          e64);
      check({tag, ".fsm"}, {62'b0, qfs}, efs);
   endtask

   task automatic set_init_all();
      e1  = {63'b0, I1};
      e2a = {62'b0, I2A};
      e2b = {62'b0, I2B};
      e64 = I64;
      efs = {62'b0, IFS};
   endtask

   // One rising edge: predict from the inputs present at the edge, then compare 1 time unit later.
   task automatic step(input string tag);
      logic [63:0] n1, n2a, n2b, n64, nfs;
      n1  = ref_next(rst_n, clr, stall, {63'b0, d1}, e1, {63'b0, I1});
      n2a = ref_next(rst_n, clr, stall, {62'b0, d2}, e2a, {62'b0, I2A});
      n2b = ref_next(rst_n, clr, stall, {62'b0, d2}, e2b, {62'b0, I2B});
      n64 = ref_next(rst_n, clr, stall, d64, e64, I64);
      nfs = ref_next(rst_n, 1'b0, 1'b0, {62'b0, dfs}, efs, {62'b0, IFS});
      @(posedge clk);
      e1 = n1; e2a = n2a; e2b = n2b; e64 = n64; efs = nfs;
      #1;
      check_all(tag);
      $display("step %-10s rst_n=%b clr=%b stall=%b d2=%b q2a=%b q2b=%b qfs=%b q64=%h",
               tag, rst_n, clr, stall, d2, q2a, q2b, qfs, q64);
   endtask

   // Called just after an edge: drops rst_n mid-cycle and checks q moves without a clock.
   task automatic async_reset(input string tag);
      #3;
      rst_n = 1'b0;
      set_init_all();
      #1;
      check_all(tag);
      $display("async-reset %s q2a=%b q2b=%b q64=%h", tag, q2a, q2b, q64);
   endtask

   initial begin
      rst_n = 1'b1;
      clr   = 1'b0;
      stall = 1'b0;
      d1    = 1'b0;
      d2    = 2'b11;
      d64   = 64'h0123_4567_89AB_CDEF;
      dfs   = 2'b11;
      set_init_all();

      // Reset asserted asynchronously before any edge, then held over 3 edges with d=11.
      #2;
      rst_n = 1'b0;
      #1;
      check_all("rst_async");
      check("rst_lit", {62'b0, q2a}, 64'd0);
      for (int i = 0; i < 3; i++) step("rst_hold");
      check("rst_hold_lit", {62'b0, q2a}, 64'd0);
      check("rst_w64_lit", q64, 64'hDEAD_BEEF_0000_0001);
      rst_n = 1'b1;

      // Load with one-edge latency.
      d2 = 2'b01; dfs = 2'b00;
      step("load01");
      check("load01_lit", {62'b0, q2a}, 64'd1);
      d2 = 2'b10;
      step("load10");
      check("load10_lit", {62'b0, q2a}, 64'd2);

      // Stall holds for 4 edges, then releases.
      stall = 1'b1; d2 = 2'b01;
      for (int i = 0; i < 4; i++) step("stall");
      check("stall_lit", {62'b0, q2a}, 64'd2);
      stall = 1'b0;
      step("unstall");
      check("unstall_lit", {62'b0, q2a}, 64'd1);

      // Clear beats stall and d.
      d2 = 2'b11;
      step("pre_clr");
      clr = 1'b1; stall = 1'b1; d2 = 2'b10;
      step("clr");
      check("clr_init01", {62'b0, q2b}, 64'd1);
      clr = 1'b0; stall = 1'b0;

      // Mid-operation reset discards the pending load; wide data after release.
      d64 = 64'h5555_AAAA_5555_AAAA;
      step("w64_load");
      async_reset("midop");
      step("midop_hold");
      rst_n = 1'b1;
      d64 = 64'hFFFF_FFFF_FFFF_FFFF;
      check("w64_init_lit", q64, 64'hDEAD_BEEF_0000_0001);
      step("w64_ones");
      check("w64_ones_lit", q64, 64'hFFFF_FFFF_FFFF_FFFF);

      // FSM-style usage with clr/stall tied off.
      dfs = 2'b00; step("fsm00");
      dfs = 2'b01; step("fsm01");
      dfs = 2'b10; step("fsm10");
      check("fsm10_lit", {62'b0, qfs}, 64'd2);
      dfs = 2'b00; step("fsm00b");

      // Clear on the very first edge after reset release.
      async_reset("pre_clr1");
      rst_n = 1'b1;
      clr = 1'b1; d2 = 2'b11; d64 = '1; d1 = 1'b0;
      step("clr_first");
      clr = 1'b0;

      // Randomized traffic with sporadic asynchronous resets.
      for (int i = 0; i < 300; i++) begin
         clr   = ($urandom_range(0, 7) == 0);
         stall = ($urandom_range(0, 3) == 0);
         d1    = 1'($urandom);
         d2    = 2'($urandom);
         d64   = {$urandom, $urandom};
         dfs   = 2'($urandom);
         step("rand");
         if ($urandom_range(0, 39) == 0) begin
            async_reset("rand_rst");
            step("rand_rsthold");
            rst_n = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_dff

// File: doc/dff.md
DFF -- requirements
Module: dff

Interface
REQ-001 SHALL declare parameter WIDTH, default 1, data width in bits (legal range 1..128).
REQ-002 SHALL declare parameter INIT, default all-zeros of WIDTH bits, value loaded on reset and on clear.
REQ-003 SHALL keep parameter order WIDTH then INIT, so positional override #(2, 2'b0) gives a 2-bit register resetting to 0.
REQ-004 SHALL declare port clk, input, 1, rising-edge clock.
REQ-005 SHALL declare port rst_n, input, 1, reset.
REQ-006 SHALL treat rst_n as asynchronous, active-low, with one clock.
REQ-007 SHALL declare port clr, input, 1, synchronous clear to INIT, active high.
REQ-008 SHALL declare port stall, input, 1, hold current value, active high.
REQ-009 SHALL declare port d, input, WIDTH, next value.
REQ-010 SHALL declare port q, output, WIDTH, registered value.
REQ-011 SHALL keep port order clk, rst_n, clr, stall, d, q for positional instantiation.

Function
REQ-012 SHALL load q <= d on each rising clk edge when rst_n=1, clr=0 and stall=0.
REQ-013 SHALL give load latency of exactly one cycle: d sampled at edge N appears on q immediately after edge N.
REQ-014 SHALL load q <= INIT on a rising edge when clr=1, regardless of stall and d.
REQ-015 SHALL hold q unchanged on a rising edge when clr=0 and stall=1.
REQ-016 SHALL use priority rst_n (async) > clr > stall > load.
REQ-017 SHALL drive q directly from the storage flop, with no combinational path from d, clr or stall to q.
REQ-018 SHALL store d bit-for-bit at full WIDTH, with no truncation or extension.
REQ-019 SHALL have clr/stall tied to the DISABLE constant (1'b0) make the block a plain reset-able register; the FSM state register in the instruction cache relies on this.
REQ-020 SHALL yield q=INIT for any input combination on the first edge after reset release when clr=1.

Reset
REQ-021 SHALL force q to INIT immediately when rst_n falls, without waiting for a clock edge.
REQ-022 SHALL hold q at INIT while rst_n=0, ignoring clk, clr, stall and d.
REQ-023 SHALL resume normal operation on the first rising clk edge after rst_n rises; reset release is synchronised by the instantiating system.
REQ-024 SHALL, when rst_n asserts mid-operation, discard any pending load and not restore the pre-reset value.

Structure
REQ-025 SHALL take ENABLE (1'b1) and DISABLE (1'b0) from the shared ISA/constants package/header; the block defines no local copies.
REQ-026 SHALL define no typedefs; WIDTH/INIT are plain parameters.
REQ-027 SHALL be a leaf module with no sub-modules, one always block sensitive to posedge clk and negedge rst_n.
REQ-028 SHALL include a parameterised bench (WIDTH=1, 2, 64) alongside it, as the RTL itself is small.

Verification
REQ-029 SHALL cover reset: WIDTH=2, INIT=2'b00, d=2'b11, rst_n=0 asynchronously mid-cycle -> q=2'b00 at once and held over 3 edges.
REQ-030 SHALL cover load: rst_n=1, clr=0, stall=0, d=2'b01 then 2'b10 on successive edges -> q=01 then 10, each one edge late.
REQ-031 SHALL cover stall: q=2'b10, stall=1, d=2'b01 for 4 edges -> q stays 10; drop stall -> q=01 next edge.
REQ-032 SHALL cover clear priority: INIT=2'b01, q=2'b11, clr=1, stall=1, d=2'b10 -> q=01 after one edge.
REQ-033 SHALL cover wide data: WIDTH=64, INIT=64'hDEAD_BEEF_0000_0001, reset then d=64'hFFFF_FFFF_FFFF_FFFF -> q=INIT, then all-ones next edge.
REQ-034 SHALL cover FSM usage: 2-bit instance with clr/stall=DISABLE cycling d 00->01->10->00 -> q follows d one cycle late.
